// File: rtl/smi_axi_wdata_formatter.sv
// SMI payload flits to AXI W-channel beats, split into bursts of at most BurstLen beats.
// Optional macro SMI_WDATA_ZERO_PAD_EN zeroes unstrobed bytes of a final flit.
module smi_axi_wdata_formatter #(
    parameter int FlitBytes = 8,
    parameter int BurstLen  = 16
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   smiInValid,
    input  logic [8*FlitBytes-1:0] smiInData,
    input  logic [7:0]             smiInEofc,
    output logic                   smiInStop,
    output logic                   dataOutValid,
    output logic [9*FlitBytes:0]   dataOut,
    input  logic                   dataOutStop,
    output logic                   burstDoneValid,
    output logic [7:0]             burstDoneLen,
    output logic                   frameError
);

    localparam int         DW           = 8 * FlitBytes;
    localparam logic [7:0] LAST_IDX     = 8'(BurstLen - 1);
    localparam logic [7:0] FLIT_BYTES_B = 8'(FlitBytes);

    logic                 r_valid;
    logic [9*FlitBytes:0] r_dout;
    logic [7:0]           r_beat_cnt;
    logic                 r_burst_valid;
    logic [7:0]           r_burst_len;
    logic                 r_frame_err;

    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_eofc_zero;
    logic                 w_eofc_bad;
    logic                 w_last;
    logic [FlitBytes-1:0] w_strb;
    logic [DW-1:0]        w_data;

    // Low-order byte mask for a legal final-flit count
    function automatic logic [FlitBytes-1:0] strb_mask(input logic [7:0] eofc);
        logic [FlitBytes-1:0] m;
        m = '0;
        for (int i = 0; i < FlitBytes; i++) begin
            m[i] = (8'(i) < eofc);
        end
        return m;
    endfunction

`ifdef SMI_WDATA_ZERO_PAD_EN
    // Clear every byte whose strobe is low
    function automatic logic [DW-1:0] zero_pad(input logic [DW-1:0] data,
                                               input logic [FlitBytes-1:0] strb);
        logic [DW-1:0] d;
        d = data;
        for (int i = 0; i < FlitBytes; i++) begin
            if (!strb[i]) begin
                d[8*i +: 8] = 8'h00;
            end else begin
                d[8*i +: 8] = data[8*i +: 8];
            end
        end
        return d;
    endfunction
`endif

    assign smiInStop      = r_valid && dataOutStop;
    assign w_accept       = smiInValid && !smiInStop;
    assign w_xfer         = r_valid && !dataOutStop;
    assign dataOutValid   = r_valid;
    assign dataOut        = r_dout;
    assign burstDoneValid = r_burst_valid;
    assign burstDoneLen   = r_burst_len;
    assign frameError     = r_frame_err;

    // Decode eofc into strobes, last flag and the outgoing payload
    always_comb begin
        w_eofc_zero = (smiInEofc == 8'd0);
        w_eofc_bad  = (smiInEofc > FLIT_BYTES_B);
        w_strb      = {FlitBytes{1'b1}};
        if (w_eofc_zero || w_eofc_bad) begin
            w_strb = {FlitBytes{1'b1}};
        end else begin
            w_strb = strb_mask(smiInEofc);
        end
        // Illegal counts still close the frame so the burst counter cannot drift
        w_last = !w_eofc_zero || (r_beat_cnt == LAST_IDX);
`ifdef SMI_WDATA_ZERO_PAD_EN
        w_data = zero_pad(smiInData, w_strb);
`else
        w_data = smiInData;
`endif
    end

    // Output stage, beat counter, burst report and sticky error
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_valid       <= 1'b0;
            r_dout        <= '0;
            r_beat_cnt    <= 8'd0;
            r_burst_valid <= 1'b0;
            r_burst_len   <= 8'd0;
            r_frame_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_valid    <= 1'b1;
                r_dout     <= {w_last, w_strb, w_data};
                r_beat_cnt <= w_last ? 8'd0 : (r_beat_cnt + 8'd1);
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end

            r_burst_valid <= w_accept && w_last;
            if (w_accept && w_last) begin
                r_burst_len <= r_beat_cnt;
            end else begin
                r_burst_len <= r_burst_len;
            end

            if (w_accept && w_eofc_bad) begin
                r_frame_err <= 1'b1;
            end else begin
                r_frame_err <= r_frame_err;
            end
        end
    end

endmodule
